spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
// - SPI target (slave) end of the link driven by the SPI master: shifts one word in/out per DATABITSIZE sclk pulses.
// - Single clock domain: sclk/mosi/ss are oversampled on clk_i; rx/tx word buffers sit on the clk_i side.
// - Mode 0 (CPOL=0, CPHA=0), MSB first: sample mosi on sclk rise, drive miso after sclk fall.
// PARAMETERS
// - BUFFERSIZE   2      depth in words of each of the rx and tx buffers; power of two, >=2
// - DATABITSIZE  8      bits per SPI word
// - TXIDLEWORD   all 1s word shifted out when the tx buffer is empty at word start
// PORTS
// - clk_i               in   1   system clock; must be >= 8x sclk frequency
// - rst_i               in   1   asynchronous reset, active-low
// - sclk                in   1   SPI clock from master (async)
// - mosi                in   1   master-out data (async)
// - miso                out  1   slave-out data
// - miso_oe             out  1   1 while ss asserted (synchronised); board tristates miso otherwise
// - ss                  in   1   slave select, active-low (async)
// - txbufferwriteenable in   1   push txbufferdatain; ignored when txbufferfull
// - txbufferdatain      in   DATABITSIZE  word to send
// - txbufferusage       out  clog2(BUFFERSIZE)+1  words held in tx buffer
// - txbufferfull        out  1
// - rxbufferreadenable  in   1   pop head word; ignored when rxbufferempty
// - rxbufferdataout     out  DATABITSIZE  head word of rx buffer (valid while !rxbufferempty)
// - rxbufferusage       out  clog2(BUFFERSIZE)+1
// - rxbufferempty       out  1
// - busy_o              out  1   synchronised ss asserted
// - overrun_o           out  1   sticky: received word dropped (rx full)
// - underrun_o          out  1   sticky: TXIDLEWORD sent (tx empty at word start)
// - clrerr_i            in   1   clears both sticky flags (set wins if same cycle)
// BEHAVIOUR
// - Reset (rst_i low, async): buffers empty, usage 0, full 0, empty 1, miso 1, miso_oe 0, busy_o 0, flags 0, bit count 0.
// - Sync: sclk, mosi, ss each pass 2 flops; edges detected by a 3rd flop. Edge-to-action latency 3 clk_i cycles.
// - ss fall (sync): busy_o=1, miso_oe=1, bitcnt=0, load word: tx buffer head (pop) or TXIDLEWORD (+underrun); miso=MSB.
// - sclk rise while busy: shift mosi into rx shift reg LSB; bitcnt++.
// - bitcnt reaches DATABITSIZE: next cycle push shift reg into rx buffer; if full after same-cycle pop -> drop, overrun_o=1; bitcnt=0.
// - sclk fall while busy: if bitcnt==0 and at least one word done, load next tx word (as at ss fall); else shift tx reg, miso=next bit.
// - ss rise (sync) mid-word: partial rx word discarded (no push), tx word lost, bitcnt=0, busy_o=0, miso_oe=0, miso=1.
// - sclk edges while ss high: ignored. ss glitch shorter than 2 clk_i: may be missed; no requirement.
// - Buffers: circular, pointers wrap at BUFFERSIZE; simultaneous push+pop when full (rx) or empty-free (tx) both take effect, usage unchanged.
// - Write into full tx buffer: ignored, no flag. Read of empty rx buffer: ignored, dataout undefined-stable.
// - usage/full/empty update on the clk_i edge after the push/pop.
// STRUCTURE
// - Shared include lib/spi/spi.vh: SPI mode constants, default DATABITSIZE, TXIDLEWORD default.
// - Sub-module spi_slave_phy: synchronisers, edge detect, bit counter, rx/tx shift registers; emits wordreceived/dataneeded strobes.
// - Buffers: two instances of a single-clock fifo with async active-low reset (not the dual-clock fifo).
// TESTING
// - Reset mid-word: rst_i low at bit 4 -> all outputs at reset values immediately, rx empty, no push after release.
// - Preload tx 0xA5; master sends 0x3C (sclk=clk_i/8) -> miso bits 1,0,1,0,0,1,0,1; rx head 0x3C, usage 1.
// - Tx empty, master sends 0x01 -> miso 0xFF, underrun_o=1; clrerr_i pulse -> 0.
// - BUFFERSIZE=2, three words 0x11,0x22,0x33 back-to-back, no reads -> rx holds 0x11,0x22, overrun_o=1.
// - ss raised after 5 sclk -> no rx push, busy_o 0 within 3 cycles; next full word 0x5A received correctly.
// - Continuous 4-word burst without ss release, tx 0x01..0x04 -> miso stream matches, no underrun.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared SPI target constants, PHY state encoding and flag helper.
package spi_slave_pkg;

  localparam int unsigned SPI_DEF_DATABITSIZE = 8;
  localparam int unsigned SPI_DEF_BUFFERSIZE  = 2;

  typedef enum logic [0:0] {
    PHY_IDLE   = 1'b0,
    PHY_ACTIVE = 1'b1
  } phy_state_e;

  // Sticky error flag: a set in the same cycle as a clear wins.
  function automatic logic sticky_next(input logic q, input logic set, input logic clr);
    return set | (q & ~clr);
  endfunction

endpackage

// File: rtl/spi_slave_fifo.sv
// Single-clock circular FIFO with registered usage/full/empty.
module spi_slave_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  // Pointer/occupancy update; a push into a full FIFO succeeds only alongside a pop.
  always_comb begin
    do_pop   = pop_i & ~empty_q;
    do_push  = push_i & (~full_q | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign usage_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/spi_slave_phy.sv
// SPI mode-0 bit engine: input synchronisers, edge detect, bit counter, shift registers.
module spi_slave_phy
  import spi_slave_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          ss,
  input  logic [DW-1:0] tx_word_i,
  output logic          miso,
  output logic          busy_o,
  output logic [DW-1:0] rx_word_o,
  output logic          wordreceived_c,
  output logic          dataneeded_c
);

  localparam int unsigned CW = $clog2(DW) + 1;

  phy_state_e    state_q, state_d;
  logic [2:0]    sclk_sync_q, sclk_sync_d;
  logic [2:0]    ss_sync_q, ss_sync_d;
  logic [1:0]    mosi_sync_q, mosi_sync_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [DW-1:0] rx_sr_q, rx_sr_d;
  logic [DW-1:0] tx_sr_q, tx_sr_d;
  logic          done_q, done_d;
  logic          sclk_rise, sclk_fall, ss_fall, ss_rise;

  // Two-flop synchronisers plus a third stage for edge detection.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    ss_sync_d   = {ss_sync_q[1:0], ss};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    sclk_rise   =  sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall   = ~sclk_sync_q[1] &  sclk_sync_q[2];
    ss_fall     = ~ss_sync_q[1]   &  ss_sync_q[2];
    ss_rise     =  ss_sync_q[1]   & ~ss_sync_q[2];
  end

  // Next-state: word framing, rx sampling on sclk rise, tx shifting/reload on sclk fall.
  always_comb begin
    state_d        = state_q;
    bitcnt_d       = bitcnt_q;
    rx_sr_d        = rx_sr_q;
    tx_sr_d        = tx_sr_q;
    done_d         = done_q;
    wordreceived_c = 1'b0;
    dataneeded_c   = 1'b0;

    if (state_q == PHY_ACTIVE && bitcnt_q == CW'(DW)) begin
      wordreceived_c = 1'b1;
      bitcnt_d       = '0;
      done_d         = 1'b1;
    end

    case (state_q)
      PHY_IDLE: begin
        if (ss_fall) begin
          state_d      = PHY_ACTIVE;
          bitcnt_d     = '0;
          done_d       = 1'b0;
          dataneeded_c = 1'b1;
          tx_sr_d      = tx_word_i;
        end
      end
      PHY_ACTIVE: begin
        if (ss_rise) begin
          state_d  = PHY_IDLE;
          bitcnt_d = '0;
          done_d   = 1'b0;
          tx_sr_d  = '1;
        end else if (sclk_rise) begin
          rx_sr_d  = {rx_sr_q[DW-2:0], mosi_sync_q[1]};
          bitcnt_d = bitcnt_q + CW'(1);
        end else if (sclk_fall) begin
          if (bitcnt_q == '0 && done_q) begin
            dataneeded_c = 1'b1;
            tx_sr_d      = tx_word_i;
          end else begin
            tx_sr_d = {tx_sr_q[DW-2:0], 1'b1};
          end
        end
      end
      default: state_d = PHY_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= PHY_IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      bitcnt_q    <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bitcnt_q    <= bitcnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      done_q      <= done_d;
    end
  end

  assign miso      = tx_sr_q[DW-1];
  assign busy_o    = (state_q == PHY_ACTIVE);
  assign rx_word_o = rx_sr_q;

endmodule

// File: rtl/spi_slave.sv
// SPI target: PHY plus rx/tx word FIFOs and sticky overrun/underrun flags.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned BUFFERSIZE = SPI_DEF_BUFFERSIZE,
  parameter int unsigned DATABITSIZE = SPI_DEF_DATABITSIZE,
  parameter logic [DATABITSIZE-1:0] TXIDLEWORD = '1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          sclk,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic                          ss,
  input  logic                          txbufferwriteenable,
  input  logic [DATABITSIZE-1:0]        txbufferdatain,
  output logic [$clog2(BUFFERSIZE):0]   txbufferusage,
  output logic                          txbufferfull,
  input  logic                          rxbufferreadenable,
  output logic [DATABITSIZE-1:0]        rxbufferdataout,
  output logic [$clog2(BUFFERSIZE):0]   rxbufferusage,
  output logic                          rxbufferempty,
  output logic                          busy_o,
  output logic                          overrun_o,
  output logic                          underrun_o,
  input  logic                          clrerr_i
);

  logic [DATABITSIZE-1:0] tx_head, tx_word, rx_word;
  logic                   tx_empty, tx_pop;
  logic                   rx_full;
  logic                   wordreceived, dataneeded, busy;
  logic                   overrun_set, underrun_set;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;

  spi_slave_phy #(.DW(DATABITSIZE)) u_phy (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sclk           (sclk),
    .mosi           (mosi),
    .ss             (ss),
    .tx_word_i      (tx_word),
    .miso           (miso),
    .busy_o         (busy),
    .rx_word_o      (rx_word),
    .wordreceived_c (wordreceived),
    .dataneeded_c   (dataneeded)
  );

  spi_slave_fifo #(.DEPTH(BUFFERSIZE), .WIDTH(DATABITSIZE)) u_txfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (txbufferwriteenable),
    .data_i  (txbufferdatain),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .usage_o (txbufferusage),
    .full_o  (txbufferfull),
    .empty_o (tx_empty)
  );

  spi_slave_fifo #(.DEPTH(BUFFERSIZE), .WIDTH(DATABITSIZE)) u_rxfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wordreceived),
    .data_i  (rx_word),
    .pop_i   (rxbufferreadenable),
    .data_o  (rxbufferdataout),
    .usage_o (rxbufferusage),
    .full_o  (rx_full),
    .empty_o (rxbufferempty)
  );

  // Word supply to the PHY and error-flag set/clear conditions.
  always_comb begin
    tx_word      = tx_empty ? TXIDLEWORD : tx_head;
    tx_pop       = dataneeded & ~tx_empty;
    underrun_set = dataneeded & tx_empty;
    overrun_set  = wordreceived & rx_full & ~(rxbufferreadenable & ~rxbufferempty);
    overrun_d    = sticky_next(overrun_q, overrun_set, clrerr_i);
    underrun_d   = sticky_next(underrun_q, underrun_set, clrerr_i);
  end

  // Sticky error flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign busy_o     = busy;
  assign miso_oe    = busy;
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged mode-0 master, queue model of both buffers and flags.
module tb_spi_slave;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, ss = 1'b1;
  logic       txbufferwriteenable = 1'b0, rxbufferreadenable = 1'b0, clrerr_i = 1'b0;
  logic [7:0] txbufferdatain = 8'h00;
  logic       miso, miso_oe, txbufferfull, rxbufferempty, busy_o, overrun_o, underrun_o;
  logic [7:0] rxbufferdataout;
  logic [1:0] txbufferusage, rxbufferusage;

  int         n_tests = 0;
  int         n_fail  = 0;

  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  bit         ovr_m = 1'b0, und_m = 1'b0, busy_m = 1'b0, settled = 1'b0;
  logic [7:0] cur_tx = 8'hFF;
  logic [7:0] last_miso = 8'h00;

  spi_slave dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .sclk                (sclk),
    .mosi                (mosi),
    .miso                (miso),
    .miso_oe             (miso_oe),
    .ss                  (ss),
    .txbufferwriteenable (txbufferwriteenable),
    .txbufferdatain      (txbufferdatain),
    .txbufferusage       (txbufferusage),
    .txbufferfull        (txbufferfull),
    .rxbufferreadenable  (rxbufferreadenable),
    .rxbufferdataout     (rxbufferdataout),
    .rxbufferusage       (rxbufferusage),
    .rxbufferempty       (rxbufferempty),
    .busy_o              (busy_o),
    .overrun_o           (overrun_o),
    .underrun_o          (underrun_o),
    .clrerr_i            (clrerr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Idle-state comparison of every observable output against the model.
  always @(negedge clk_i) begin
    if (settled) begin
      chk("rx_usage", 32'(rxbufferusage), 32'(rx_m.size()));
      chk("rx_empty", 32'(rxbufferempty), 32'(rx_m.size() == 0));
      if (rx_m.size() > 0) chk("rx_head", 32'(rxbufferdataout), 32'(rx_m[0]));
      chk("tx_usage", 32'(txbufferusage), 32'(tx_m.size()));
      chk("tx_full", 32'(txbufferfull), 32'(tx_m.size() == 2));
      chk("overrun", 32'(overrun_o), 32'(ovr_m));
      chk("underrun", 32'(underrun_o), 32'(und_m));
      chk("busy", 32'(busy_o), 32'(busy_m));
      chk("miso_oe", 32'(miso_oe), 32'(busy_m));
      if (!busy_m) chk("miso_idle", 32'(miso), 32'd1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    cyc(3);
    settled = 1'b1;
  endtask

  // A word starts: take the tx head, or the idle word with an underrun.
  task automatic begin_word();
    if (tx_m.size() > 0) cur_tx = tx_m.pop_front();
    else begin
      cur_tx = 8'hFF;
      und_m  = 1'b1;
    end
  endtask

  task automatic tx_write(input logic [7:0] v);
    txbufferdatain      = v;
    txbufferwriteenable = 1'b1;
    cyc(1);
    txbufferwriteenable = 1'b0;
    if (tx_m.size() < 2) tx_m.push_back(v);
  endtask

  task automatic rx_read();
    settled            = 1'b0;
    rxbufferreadenable = 1'b1;
    cyc(1);
    rxbufferreadenable = 1'b0;
    if (rx_m.size() > 0) void'(rx_m.pop_front());
    settle();
  endtask

  task automatic clr_err();
    settled  = 1'b0;
    clrerr_i = 1'b1;
    cyc(1);
    clrerr_i = 1'b0;
    ovr_m    = 1'b0;
    und_m    = 1'b0;
    settle();
  endtask

  task automatic ss_low();
    settled = 1'b0;
    ss      = 1'b0;
    begin_word();
    busy_m  = 1'b1;
    cyc(8);
    chk("busy_on", 32'(busy_o), 32'd1);
    chk("oe_on", 32'(miso_oe), 32'd1);
  endtask

  task automatic ss_high();
    cyc(4);
    ss = 1'b1;
    cyc(3);
    chk("busy_off_3cyc", 32'(busy_o), 32'd0);
    busy_m = 1'b0;
    cyc(5);
    settled = 1'b1;
  endtask

  // Master shifts nbits of w (sclk = clk/8); checks each miso bit before the rising edge.
  task automatic send_word(input logic [7:0] w, input int nbits, input bit push_en,
                           input logic [7:0] push_v);
    logic [7:0] got;
    got = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      mosi = w[7-i];
      if (push_en && i == 3) begin
        tx_write(push_v);
        cyc(3);
      end else begin
        cyc(4);
      end
      chk("miso_bit", 32'(miso), 32'(cur_tx[7-i]));
      got[7-i] = miso;
      sclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
    end
    last_miso = got;
    if (nbits == 8) begin
      if (rx_m.size() < 2) rx_m.push_back(w);
      else ovr_m = 1'b1;
      begin_word();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values.
    cyc(3);
    chk("rst_miso", 32'(miso), 32'd1);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rx_empty", 32'(rxbufferempty), 32'd1);
    chk("rst_rx_usage", 32'(rxbufferusage), 32'd0);
    chk("rst_tx_usage", 32'(txbufferusage), 32'd0);
    chk("rst_flags", 32'({overrun_o, underrun_o}), 32'd0);
    rst_i = 1'b1;
    settle();

    // Preloaded 0xA5 out while 0x3C comes in.
    settled = 1'b0;
    tx_write(8'hA5);
    settle();
    ss_low();
    send_word(8'h3C, 8, 1'b0, 8'h00);
    chk("t1_miso_word", 32'(last_miso), 32'hA5);
    ss_high();
    chk("t1_rx_head", 32'(rxbufferdataout), 32'h3C);
    chk("t1_rx_usage", 32'(rxbufferusage), 32'd1);
    clr_err();

    // Empty tx buffer: idle word and underrun, then cleared.
    ss_low();
    send_word(8'h01, 8, 1'b0, 8'h00);
    chk("t2_miso_word", 32'(last_miso), 32'hFF);
    ss_high();
    chk("t2_underrun", 32'(underrun_o), 32'd1);
    clr_err();
    chk("t2_underrun_clr", 32'(underrun_o), 32'd0);
    chk("t2_rx_head", 32'(rxbufferdataout), 32'h3C);
    rx_read();
    rx_read();

    // Three words into a two-deep rx buffer.
    ss_low();
    send_word(8'h11, 8, 1'b0, 8'h00);
    send_word(8'h22, 8, 1'b0, 8'h00);
    send_word(8'h33, 8, 1'b0, 8'h00);
    ss_high();
    chk("t3_rx_usage", 32'(rxbufferusage), 32'd2);
    chk("t3_overrun", 32'(overrun_o), 32'd1);
    chk("t3_head0", 32'(rxbufferdataout), 32'h11);
    rx_read();
    chk("t3_head1", 32'(rxbufferdataout), 32'h22);
    rx_read();
    clr_err();

    // Aborted word after 5 bits, then a clean 0x5A.
    ss_low();
    send_word(8'hE7, 5, 1'b0, 8'h00);
    ss_high();
    chk("t4_no_push", 32'(rxbufferusage), 32'd0);
    ss_low();
    send_word(8'h5A, 8, 1'b0, 8'h00);
    ss_high();
    chk("t4_rx_head", 32'(rxbufferdataout), 32'h5A);
    rx_read();
    clr_err();

    // Four-word burst with tx refilled mid-word.
    settled = 1'b0;
    tx_write(8'h01);
    tx_write(8'h02);
    settle();
    chk("t5_tx_full", 32'(txbufferfull), 32'd1);
    ss_low();
    send_word(8'hC1, 8, 1'b1, 8'h03);
    chk("t5_w1", 32'(last_miso), 32'h01);
    send_word(8'hC2, 8, 1'b1, 8'h04);
    chk("t5_w2", 32'(last_miso), 32'h02);
    send_word(8'hC3, 8, 1'b1, 8'h05);
    chk("t5_w3", 32'(last_miso), 32'h03);
    send_word(8'hC4, 8, 1'b0, 8'h00);
    chk("t5_w4", 32'(last_miso), 32'h04);
    ss_high();
    chk("t5_no_underrun", 32'(underrun_o), 32'd0);
    rx_read();
    rx_read();
    clr_err();

    // Reset in the middle of a word.
    settled = 1'b0;
    tx_write(8'h77);
    settle();
    ss_low();
    send_word(8'hC3, 4, 1'b0, 8'h00);
    rst_i = 1'b0;
    #1;
    chk("rw_miso", 32'(miso), 32'd1);
    chk("rw_oe", 32'(miso_oe), 32'd0);
    chk("rw_busy", 32'(busy_o), 32'd0);
    chk("rw_rx_empty", 32'(rxbufferempty), 32'd1);
    chk("rw_tx_usage", 32'(txbufferusage), 32'd0);
    chk("rw_flags", 32'({overrun_o, underrun_o}), 32'd0);
    tx_m.delete();
    rx_m.delete();
    ovr_m  = 1'b0;
    und_m  = 1'b0;
    busy_m = 1'b0;
    ss     = 1'b1;
    sclk   = 1'b0;
    cyc(2);
    rst_i = 1'b1;
    cyc(10);
    settled = 1'b1;
    cyc(4);
    chk("rw_no_push", 32'(rxbufferusage), 32'd0);

    settled = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
